chacha_core: RTL and testbench

- Parametrised ChaCha permutation engine with valid/ready handshakes on input and output.
- Round count and the number of double rounds evaluated per clock are selectable.
- Supports ChaCha (feed-forward add) and HChaCha (raw permuted state, no feed-forward).
- Sits between the key/nonce/counter state builder and the keystream XOR or subkey-derivation logic.

---
 rtl/chacha_pkg.sv | 45 ++++
 rtl/chacha_double_round.sv | 37 +++
 rtl/chacha_core.sv | 126 ++++++++++++
 tb/tb_chacha_core.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chacha_pkg.sv
// Shared types, constants and round primitives for the ChaCha permutation core.
package chacha_pkg;

  typedef logic [31:0] word_t;
  typedef word_t [0:15] state_t;
  typedef word_t [0:3]  qr_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROUND,
    ST_DONE
  } core_state_e;

  localparam word_t CHACHA_SIGMA0 = 32'h61707865;
  localparam word_t CHACHA_SIGMA1 = 32'h3320646e;
  localparam word_t CHACHA_SIGMA2 = 32'h79622d32;
  localparam word_t CHACHA_SIGMA3 = 32'h6b206574;

  function automatic word_t rotl32(input word_t v, input int unsigned n);
    return (v << n) | (v >> (32 - n));
  endfunction

  // RFC 8439 quarter round; returns {a, b, c, d} after the update.
  function automatic qr_t quarter_round(input word_t a_i, input word_t b_i,
                                        input word_t c_i, input word_t d_i);
    word_t a, b, c, d;
    a = a_i;
    b = b_i;
    c = c_i;
    d = d_i;
    a = a + b; d = rotl32(d ^ a, 16);
    c = c + d; b = rotl32(b ^ c, 12);
    a = a + b; d = rotl32(d ^ a, 8);
    c = c + d; b = rotl32(b ^ c, 7);
    return {a, b, c, d};
  endfunction

  // Legal configurations: 8/12/20 rounds, double rounds per clock dividing ROUNDS/2.
  function automatic bit chacha_params_ok(input int rounds, input int dr);
    bit rounds_ok;
    rounds_ok = (rounds == 8) || (rounds == 12) || (rounds == 20);
    return rounds_ok && (dr >= 1) && (((rounds / 2) % dr) == 0);
  endfunction

endpackage

// File: rtl/chacha_double_round.sv
// One ChaCha double round (column pass then diagonal pass), purely combinational.
module chacha_double_round
  import chacha_pkg::*;
(
  input  state_t s_in,
  output state_t s_out
);

  state_t col;

  always_comb begin
    qr_t q;
    col = s_in;
    for (int i = 0; i < 4; i++) begin
      q = quarter_round(s_in[i], s_in[i + 4], s_in[i + 8], s_in[i + 12]);
      col[i]      = q[0];
      col[i + 4]  = q[1];
      col[i + 8]  = q[2];
      col[i + 12] = q[3];
    end
  end

  // Diagonal i touches words i, 4+(i+1)%4, 8+(i+2)%4, 12+(i+3)%4.
  always_comb begin
    qr_t q;
    s_out = col;
    for (int i = 0; i < 4; i++) begin
      q = quarter_round(col[i], col[4 + ((i + 1) % 4)],
                        col[8 + ((i + 2) % 4)], col[12 + ((i + 3) % 4)]);
      s_out[i]                = q[0];
      s_out[4 + ((i + 1) % 4)]  = q[1];
      s_out[8 + ((i + 2) % 4)]  = q[2];
      s_out[12 + ((i + 3) % 4)] = q[3];
    end
  end

endmodule

// File: rtl/chacha_core.sv
// Iterative ChaCha/HChaCha permutation engine with valid/ready handshakes.
module chacha_core
  import chacha_pkg::*;
#(
  parameter int ROUNDS       = 20,
  parameter int DR_PER_CYCLE = 1
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   in_valid,
  output logic   in_ready,
  input  state_t in_state,
  input  logic   in_mode,
  output logic   out_valid,
  input  logic   out_ready,
  output state_t out_state
);

  localparam int N     = ROUNDS / (2 * DR_PER_CYCLE);
  localparam int CNT_W = $clog2(N + 1);

  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t CNT_LAST = cnt_t'(N - 1);

  if (!chacha_params_ok(ROUNDS, DR_PER_CYCLE)) begin : g_param_check
    $error("chacha_core: illegal ROUNDS=%0d / DR_PER_CYCLE=%0d", ROUNDS, DR_PER_CYCLE);
  end

  core_state_e state, state_nx;
  cnt_t        cnt, cnt_nx;
  logic        accept, last;

  state_t x, init, x_next;
  logic   mode;

  state_t [DR_PER_CYCLE:0] chain;

  function automatic state_t feed_forward(input state_t a, input state_t b);
    state_t r;
    for (int i = 0; i < 16; i++) begin
      r[i] = a[i] + b[i];
    end
    return r;
  endfunction

  assign chain[0] = x;

  for (genvar g = 0; g < DR_PER_CYCLE; g++) begin : g_dr
    chacha_double_round u_dr (
      .s_in  (chain[g]),
      .s_out (chain[g + 1])
    );
  end

  assign x_next    = chain[DR_PER_CYCLE];
  assign out_valid = (state == ST_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    in_ready = 1'b0;
    accept   = 1'b0;
    last     = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept   = 1'b1;
          cnt_nx   = '0;
          state_nx = ST_ROUND;
        end
      end
      ST_ROUND: begin
        cnt_nx = cnt + 1'b1;
        if (cnt == CNT_LAST) begin
          last     = 1'b1;
          state_nx = ST_DONE;
        end
      end
      ST_DONE: begin
        // A retiring block frees the core for a same-edge acceptance.
        in_ready = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            accept   = 1'b1;
            cnt_nx   = '0;
            state_nx = ST_ROUND;
          end else begin
            state_nx = ST_IDLE;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Working state, original input and mode are captured at acceptance only.
  always_ff @(posedge clk) begin
    if (accept) begin
      x    <= in_state;
      init <= in_state;
      mode <= in_mode;
    end else if (state == ST_ROUND) begin
      x <= x_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_state <= '0;
    end else if (last) begin
      out_state <= mode ? x_next : feed_forward(x_next, init);
    end
  end

endmodule

// File: tb/tb_chacha_core.sv
// Scoreboard bench for chacha_core: RFC vectors, backpressure, back-to-back, reset, parameter sweep.
module tb_chacha_core;
  import chacha_pkg::*;

  logic   clk = 1'b0;
  logic   rst;
  logic   in_valid, in_ready, in_mode, out_valid, out_ready;
  state_t in_state, out_state;

  logic   sw_valid, sw_mode, sw_oready;
  state_t sw_state;
  logic   sw_rdy [3];
  logic   sw_ov  [3];
  state_t sw_out [3];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  chacha_core dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
    .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state)
  );

  chacha_core #(.ROUNDS(8), .DR_PER_CYCLE(4)) dut_r8 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_rdy[0]), .in_state(sw_state),
    .in_mode(sw_mode), .out_valid(sw_ov[0]), .out_ready(sw_oready), .out_state(sw_out[0])
  );

  chacha_core #(.ROUNDS(12), .DR_PER_CYCLE(2)) dut_r12 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_rdy[1]), .in_state(sw_state),
    .in_mode(sw_mode), .out_valid(sw_ov[1]), .out_ready(sw_oready), .out_state(sw_out[1])
  );

  chacha_core #(.ROUNDS(20), .DR_PER_CYCLE(5)) dut_r20 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_rdy[2]), .in_state(sw_state),
    .in_mode(sw_mode), .out_valid(sw_ov[2]), .out_ready(sw_oready), .out_state(sw_out[2])
  );

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model
  function automatic word_t rl(input word_t v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic state_t ref_qr(input state_t s, input int a, input int b, input int c, input int d);
    s[a] = s[a] + s[b]; s[d] = rl(s[d] ^ s[a], 16);
    s[c] = s[c] + s[d]; s[b] = rl(s[b] ^ s[c], 12);
    s[a] = s[a] + s[b]; s[d] = rl(s[d] ^ s[a], 8);
    s[c] = s[c] + s[d]; s[b] = rl(s[b] ^ s[c], 7);
    return s;
  endfunction

  function automatic state_t ref_block(input state_t s, input logic m, input int rounds);
    state_t x = s;
    for (int r = 0; r < rounds / 2; r++) begin
      x = ref_qr(x, 0, 4, 8, 12);
      x = ref_qr(x, 1, 5, 9, 13);
      x = ref_qr(x, 2, 6, 10, 14);
      x = ref_qr(x, 3, 7, 11, 15);
      x = ref_qr(x, 0, 5, 10, 15);
      x = ref_qr(x, 1, 6, 11, 12);
      x = ref_qr(x, 2, 7, 8, 13);
      x = ref_qr(x, 3, 4, 9, 14);
    end
    if (!m) for (int i = 0; i < 16; i++) x[i] = x[i] + s[i];
    return x;
  endfunction

  function automatic state_t mk_state(input word_t w12, input word_t w13, input word_t w14, input word_t w15);
    state_t s;
    s[0] = CHACHA_SIGMA0; s[1] = CHACHA_SIGMA1; s[2] = CHACHA_SIGMA2; s[3] = CHACHA_SIGMA3;
    for (int k = 0; k < 8; k++) s[4 + k] = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
    s[12] = w12; s[13] = w13; s[14] = w14; s[15] = w15;
    return s;
  endfunction

  function automatic state_t rand_state();
    state_t s;
    for (int i = 0; i < 16; i++) s[i] = $urandom();
    return s;
  endfunction

  // Scoreboard on the main DUT, sampled on the falling edge
  typedef struct {
    state_t exp;
    int     acc;
  } sb_t;
  sb_t  sbq [$];
  int   last_acc = -1;
  int   last_ret = -2;
  logic ov_prev  = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
      ov_prev = 1'b0;
    end else begin
      if (out_valid && !ov_prev) begin
        if (sbq.size() == 0) chk("sb_empty", 512'(sbq.size()), 512'd1);
        else chk("latency", 512'(cyc - sbq[0].acc), 512'd10);
      end
      if (out_valid && out_ready && sbq.size() > 0) begin
        chk("sb_data", out_state, sbq[0].exp);
        void'(sbq.pop_front());
        last_ret = cyc + 1;
      end
      if (in_valid && in_ready) begin
        sbq.push_back('{exp: ref_block(in_state, in_mode, 20), acc: cyc + 1});
        last_acc = cyc + 1;
      end
      ov_prev = out_valid;
    end
  end

  task automatic send(input state_t s, input logic m);
    int n = 0;
    in_state = s;
    in_mode  = m;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 100);
    if (!in_ready) chk("send_timeout", 512'(in_ready), 512'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_mode  = ~m;
  endtask

  task automatic wait_ov(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 100);
    if (!out_valid) chk(tag, 512'(out_valid), 512'd1);
  endtask

  task automatic sweep_block(input state_t s, input logic m);
    int  rnds [3] = '{8, 12, 20};
    int  elat [3] = '{1, 3, 2};
    int  lat  [3] = '{-1, -1, -1};
    int  acc;
    @(posedge clk);
    #1;
    sw_state = s;
    sw_mode  = m;
    sw_valid = 1'b1;
    acc = cyc + 1;
    @(posedge clk);
    #1;
    sw_valid = 1'b0;
    sw_mode  = ~m;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (sw_ov[d] && lat[d] < 0) begin
          lat[d] = cyc - acc;
          chk($sformatf("sweep%0d_data", rnds[d]), sw_out[d], ref_block(s, m, rnds[d]));
        end
      end
    end
    for (int d = 0; d < 3; d++) chk($sformatf("sweep%0d_lat", rnds[d]), 512'(lat[d]), 512'(elat[d]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    state_t v1, v2, hv, b2, saved, r;
    int     n;

    v1 = mk_state(32'h00000001, 32'h09000000, 32'h4a000000, 32'h00000000);
    b2 = mk_state(32'h00000002, 32'h09000000, 32'h4a000000, 32'h00000000);
    hv = mk_state(32'h09000000, 32'h4a000000, 32'h00000000, 32'h27594131);

    rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_state = '0; out_ready = 1'b1;
    sw_valid = 1'b0; sw_mode = 1'b0; sw_state = '0; sw_oready = 1'b1;
    #1;
    chk("rst_in_ready", 512'(in_ready), 512'd1);
    chk("rst_out_valid", 512'(out_valid), 512'd0);
    chk("rst_out_state", out_state, 512'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // RFC 8439 block function vector
    send(v1, 1'b0);
    wait_ov("t1_timeout");
    chk("t1_w0", 512'(out_state[0]), 512'h e4e7f110);
    chk("t1_w1", 512'(out_state[1]), 512'h 15593bd1);
    chk("t1_w2", 512'(out_state[2]), 512'h 1fdd0f50);
    chk("t1_w3", 512'(out_state[3]), 512'h c47120a3);
    chk("t1_w15", 512'(out_state[15]), 512'h 4e3c50a2);

    // HChaCha20
    send(hv, 1'b1);
    wait_ov("t2_timeout");
    chk("t2_w0", 512'(out_state[0]), 512'h 423b4182);
    chk("t2_w1", 512'(out_state[1]), 512'h fe7bb227);
    chk("t2_w2", 512'(out_state[2]), 512'h 50420ed3);
    chk("t2_w3", 512'(out_state[3]), 512'h 737d878a);
    chk("t2_w12", 512'(out_state[12]), 512'h d5e4f9a0);
    chk("t2_w13", 512'(out_state[13]), 512'h 53a8748a);
    chk("t2_w14", 512'(out_state[14]), 512'h 13c42ec1);
    chk("t2_w15", 512'(out_state[15]), 512'h dcecd326);

    // Backpressure
    @(posedge clk);
    #1 out_ready = 1'b0;
    send(v1, 1'b0);
    wait_ov("t3_timeout");
    saved = out_state;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 512'(out_valid), 512'd1);
      chk("bp_in_ready", 512'(in_ready), 512'd0);
      chk("bp_stable", out_state, saved);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_retired", 512'(out_valid), 512'd0);
    chk("bp_idle_ready", 512'(in_ready), 512'd1);

    // Back-to-back
    send(v1, 1'b0);
    send(b2, 1'b0);
    chk("b2b_acc_on_retire", 512'(last_acc), 512'(last_ret));
    wait_ov("t4_timeout");
    r = ref_block(b2, 1'b0, 20);
    chk("b2b_w0", 512'(out_state[0]), 512'(r[0]));

    // Reset in the middle of ROUND
    repeat (3) @(posedge clk);
    #1;
    send(v2_rand(), 1'b0);
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", 512'(in_ready), 512'd1);
    chk("mid_rst_out_valid", 512'(out_valid), 512'd0);
    chk("mid_rst_out_state", out_state, 512'd0);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    chk("mid_rst_no_ov", 512'(n), 512'd0);
    send(v1, 1'b0);
    wait_ov("t5_timeout");
    chk("post_rst_w0", 512'(out_state[0]), 512'h e4e7f110);

    // Random blocks through the scoreboard
    for (int i = 0; i < 4; i++) begin
      send(rand_state(), 1'($urandom_range(0, 1)));
      wait_ov("rand_timeout");
    end

    // Parameter sweep
    sweep_block(v1, 1'b0);
    sweep_block(rand_state(), 1'b1);

    repeat (3) @(posedge clk);
    chk("sb_drain", 512'(sbq.size()), 512'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  function automatic state_t v2_rand();
    return rand_state();
  endfunction

endmodule
